// File: rtl/lru_pkg.sv
// Shared types and helpers for the set-associative true-LRU replacement unit.
package lru_pkg;

    localparam int unsigned MAX_WAYS = 8;
    localparam int unsigned MAX_MAT_W = MAX_WAYS * MAX_WAYS;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_TOUCH = 2'd1,
        OP_FILL  = 2'd2,
        OP_INVAL = 2'd3
    } lru_op_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } lru_state_e;

    // Flat row-major age matrix (bit i*ways+j) where way i is newer than way j iff i>j.
    function automatic logic [MAX_MAT_W-1:0] lru_reset_matrix(input int unsigned ways);
        logic [MAX_MAT_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < ways; i++) begin
            for (int unsigned j = 0; j < ways; j++) begin
                if (i > j) m[i*ways+j] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/lru_victim_select.sv
// Picks a victim for one set: lowest-index invalid way first, else the way whose row is all 0s.
module lru_victim_select #(
    parameter  int unsigned ASSOCIATIVITY = 4,
    localparam int unsigned WAY_W         = $clog2(ASSOCIATIVITY),
    localparam int unsigned MAT_W         = ASSOCIATIVITY * ASSOCIATIVITY
) (
    input  logic [MAT_W-1:0]         mat,
    input  logic [ASSOCIATIVITY-1:0] vld,
    output logic [WAY_W-1:0]         way_c,
    output logic                     free_c
);

    logic row_any;

    always_comb begin
        way_c   = '0;
        free_c  = 1'b0;
        row_any = 1'b0;
        for (int unsigned i = 0; i < ASSOCIATIVITY; i++) begin
            if (!vld[i] && !free_c) begin
                free_c = 1'b1;
                way_c  = WAY_W'(i);
            end
        end
        // Diagonal bits are never set, so OR-ing the whole row is safe.
        if (!free_c) begin
            for (int unsigned i = 0; i < ASSOCIATIVITY; i++) begin
                row_any = 1'b0;
                for (int unsigned j = 0; j < ASSOCIATIVITY; j++) begin
                    row_any = row_any | mat[i*ASSOCIATIVITY+j];
                end
                if (!row_any) way_c = WAY_W'(i);
            end
        end
    end

endmodule

// File: rtl/set_assoc_lru.sv
// Per-set true-LRU age matrices and valid vectors with registered victim queries and a flush sweep.
module set_assoc_lru
    import lru_pkg::*;
#(
    parameter  int unsigned ASSOCIATIVITY = 4,
    parameter  int unsigned NUM_SETS      = 16,
    localparam int unsigned WAY_W         = $clog2(ASSOCIATIVITY),
    localparam int unsigned SET_W         = $clog2(NUM_SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             upd_valid,
    input  lru_op_e          upd_op,
    input  logic [SET_W-1:0] upd_set,
    input  logic [WAY_W-1:0] upd_way,
    input  logic             qry_valid,
    input  logic [SET_W-1:0] qry_set,
    input  logic             flush_req,
    output logic             victim_valid,
    output logic [WAY_W-1:0] victim_way,
    output logic             victim_free,
    output logic             busy
);

    localparam int unsigned MAT_W = ASSOCIATIVITY * ASSOCIATIVITY;
    localparam logic [MAT_W-1:0] RESET_MAT = MAT_W'(lru_reset_matrix(ASSOCIATIVITY));
    localparam logic [SET_W-1:0] LAST_SET  = SET_W'(NUM_SETS - 1);

    logic [MAT_W-1:0]         mat_q [NUM_SETS];
    logic [ASSOCIATIVITY-1:0] vld_q [NUM_SETS];
    lru_state_e               state_q;
    logic [SET_W-1:0]         flush_cnt_q;

    logic [MAT_W-1:0]         upd_mat_c;
    logic [ASSOCIATIVITY-1:0] upd_vld_c;
    logic                     upd_en_c;
    logic [WAY_W-1:0]         sel_way_c;
    logic                     sel_free_c;

    // Next matrix/valid for the set under update: touch/fill make the way MRU, inval makes it LRU.
    always_comb begin
        upd_mat_c = mat_q[upd_set];
        upd_vld_c = vld_q[upd_set];
        upd_en_c  = upd_valid && (upd_op != OP_NONE);
        for (int unsigned i = 0; i < ASSOCIATIVITY; i++) begin
            for (int unsigned j = 0; j < ASSOCIATIVITY; j++) begin
                if (i != j) begin
                    if (32'(upd_way) == i)      upd_mat_c[i*ASSOCIATIVITY+j] = (upd_op != OP_INVAL);
                    else if (32'(upd_way) == j) upd_mat_c[i*ASSOCIATIVITY+j] = (upd_op == OP_INVAL);
                end
            end
        end
        if (upd_op == OP_FILL)       upd_vld_c[upd_way] = 1'b1;
        else if (upd_op == OP_INVAL) upd_vld_c[upd_way] = 1'b0;
    end

    lru_victim_select #(
        .ASSOCIATIVITY (ASSOCIATIVITY)
    ) u_victim_select (
        .mat    (mat_q[qry_set]),
        .vld    (vld_q[qry_set]),
        .way_c  (sel_way_c),
        .free_c (sel_free_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                mat_q[s] <= RESET_MAT;
                vld_q[s] <= '0;
            end
            state_q      <= S_IDLE;
            flush_cnt_q  <= '0;
            victim_valid <= 1'b0;
            victim_way   <= '0;
            victim_free  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Query reads pre-update state; both are accepted in the flush_req cycle too.
                    victim_valid <= qry_valid;
                    if (qry_valid) begin
                        victim_way  <= sel_way_c;
                        victim_free <= sel_free_c;
                    end
                    if (upd_en_c) begin
                        mat_q[upd_set] <= upd_mat_c;
                        vld_q[upd_set] <= upd_vld_c;
                    end
                    if (flush_req) begin
                        state_q     <= S_FLUSH;
                        flush_cnt_q <= '0;
                        busy        <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    victim_valid       <= 1'b0;
                    mat_q[flush_cnt_q] <= RESET_MAT;
                    vld_q[flush_cnt_q] <= '0;
                    flush_cnt_q        <= flush_cnt_q + SET_W'(1);
                    if (flush_cnt_q == LAST_SET) begin
                        state_q <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_set_assoc_lru.sv
// Directed bench for set_assoc_lru with a recency-list model checked every cycle plus literal expectations.
module tb_set_assoc_lru;
    import lru_pkg::*;

    localparam int A  = 4;
    localparam int NS = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       upd_valid = 1'b0;
    lru_op_e    upd_op = OP_NONE;
    logic [2:0] upd_set = '0;
    logic [1:0] upd_way = '0;
    logic       qry_valid = 1'b0;
    logic [2:0] qry_set = '0;
    logic       flush_req = 1'b0;
    logic       victim_valid;
    logic [1:0] victim_way;
    logic       victim_free;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    set_assoc_lru #(.ASSOCIATIVITY(A), .NUM_SETS(NS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .upd_valid    (upd_valid),
        .upd_op       (upd_op),
        .upd_set      (upd_set),
        .upd_way      (upd_way),
        .qry_valid    (qry_valid),
        .qry_set      (qry_set),
        .flush_req    (flush_req),
        .victim_valid (victim_valid),
        .victim_way   (victim_way),
        .victim_free  (victim_free),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    // Model: per set, ways ordered from LRU (index 0) to MRU (index A-1), plus a valid bit per way.
    int ord [NS][A];
    bit mv  [NS][A];
    int exp_vv, exp_way, exp_free, exp_busy;
    int m_flushing, m_cnt;

    function automatic void m_reset_set(int s);
        for (int k = 0; k < A; k++) begin
            ord[s][k] = k;
            mv[s][k]  = 1'b0;
        end
    endfunction

    function automatic int m_pos(int s, int w);
        int p = 0;
        for (int k = 0; k < A; k++) if (ord[s][k] == w) p = k;
        return p;
    endfunction

    function automatic void m_to_mru(int s, int w);
        for (int k = m_pos(s, w); k < A - 1; k++) ord[s][k] = ord[s][k+1];
        ord[s][A-1] = w;
    endfunction

    function automatic void m_to_lru(int s, int w);
        for (int k = m_pos(s, w); k > 0; k--) ord[s][k] = ord[s][k-1];
        ord[s][0] = w;
    endfunction

    function automatic void m_victim(int s, output int w, output int f);
        w = ord[s][0];
        f = 0;
        for (int k = A - 1; k >= 0; k--) begin
            if (!mv[s][k]) begin
                w = k;
                f = 1;
            end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NS; s++) m_reset_set(s);
            exp_vv = 0; exp_way = 0; exp_free = 0; exp_busy = 0;
            m_flushing = 0; m_cnt = 0;
        end else if (m_flushing != 0) begin
            exp_vv = 0;
            m_reset_set(m_cnt);
            if (m_cnt == NS - 1) begin
                m_flushing = 0;
                exp_busy   = 0;
            end
            m_cnt++;
        end else begin
            exp_vv = 0;
            if (qry_valid) begin
                m_victim(int'(qry_set), exp_way, exp_free);
                exp_vv = 1;
            end
            if (upd_valid) begin
                case (upd_op)
                    OP_TOUCH: m_to_mru(int'(upd_set), int'(upd_way));
                    OP_FILL: begin
                        m_to_mru(int'(upd_set), int'(upd_way));
                        mv[upd_set][upd_way] = 1'b1;
                    end
                    OP_INVAL: begin
                        m_to_lru(int'(upd_set), int'(upd_way));
                        mv[upd_set][upd_way] = 1'b0;
                    end
                    default: ;
                endcase
            end
            if (flush_req) begin
                m_flushing = 1;
                m_cnt      = 0;
                exp_busy   = 1;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("busy", int'(busy), exp_busy);
        check("victim_valid", int'(victim_valid), exp_vv);
        if (exp_vv != 0) begin
            check("victim_way", int'(victim_way), exp_way);
            check("victim_free", int'(victim_free), exp_free);
        end
    end

    task automatic do_upd(input lru_op_e op, input int s, input int w);
        upd_valid = 1'b1; upd_op = op; upd_set = 3'(s); upd_way = 2'(w);
        @(negedge clk);
        upd_valid = 1'b0; upd_op = OP_NONE;
    endtask

    task automatic fill_set(input int s);
        for (int w = 0; w < A; w++) do_upd(OP_FILL, s, w);
    endtask

    task automatic do_qry(input string name, input int s, input int ew, input int ef);
        qry_valid = 1'b1; qry_set = 3'(s);
        @(negedge clk);
        qry_valid = 1'b0;
        check({name, "_vv"}, int'(victim_valid), 1);
        check({name, "_way"}, int'(victim_way), ew);
        check({name, "_free"}, int'(victim_free), ef);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        repeat (2) @(negedge clk);
        check("rst_vv", int'(victim_valid), 0);
        check("rst_way", int'(victim_way), 0);
        check("rst_free", int'(victim_free), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_qry("q_reset", 3, 0, 1);

        fill_set(2);
        do_qry("s2_full", 2, 0, 0);
        do_upd(OP_TOUCH, 2, 0);
        do_qry("s2_t0", 2, 1, 0);
        do_upd(OP_TOUCH, 2, 1);
        do_upd(OP_TOUCH, 2, 2);
        do_qry("s2_t12", 2, 3, 0);

        fill_set(4);
        do_upd(OP_INVAL, 4, 2);
        do_qry("s4_inval", 4, 2, 1);
        do_upd(OP_FILL, 4, 2);
        do_qry("s4_refill", 4, 0, 0);

        // Touching an invalid way leaves it invalid.
        do_upd(OP_TOUCH, 7, 0);
        do_qry("s7_touch_inv", 7, 0, 1);

        fill_set(5);
        upd_valid = 1'b1; upd_op = OP_TOUCH; upd_set = 3'd5; upd_way = 2'd0;
        qry_valid = 1'b1; qry_set = 3'd5;
        @(negedge clk);
        upd_valid = 1'b0; upd_op = OP_NONE; qry_valid = 1'b0;
        check("s5_same_way", int'(victim_way), 0);
        check("s5_same_free", int'(victim_free), 0);
        do_qry("s5_after", 5, 1, 0);

        // Back-to-back queries to different sets.
        qry_valid = 1'b1; qry_set = 3'd2;
        @(negedge clk);
        qry_set = 3'd3;
        @(negedge clk);
        qry_valid = 1'b0;
        check("b2b_way", int'(victim_way), 0);
        check("b2b_free", int'(victim_free), 1);

        // Flush with a query accepted in the request cycle, traffic dropped during the sweep.
        flush_req = 1'b1; qry_valid = 1'b1; qry_set = 3'd2;
        @(negedge clk);
        flush_req = 1'b0; qry_valid = 1'b0;
        check("flush_req_qry_way", int'(victim_way), 3);
        cnt = 0;
        while (busy && cnt < 20) begin
            cnt++;
            upd_valid = 1'b1; upd_op = OP_FILL; upd_set = 3'(cnt % NS); upd_way = 2'(cnt % A);
            qry_valid = 1'b1; qry_set = 3'(cnt % NS);
            flush_req = 1'b1;
            @(negedge clk);
        end
        upd_valid = 1'b0; upd_op = OP_NONE; qry_valid = 1'b0; flush_req = 1'b0;
        check("busy_len", cnt, NS);
        for (int s = 0; s < NS; s++) do_qry("post_flush", s, 0, 1);

        // Async reset in the middle of a sweep.
        fill_set(6);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", int'(busy), 0);
        check("async_vv", int'(victim_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_qry("post_rst", 6, 0, 1);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
